// File: rtl/rom1p1r_128x64_arb.sv
// ---------------------------------------------------------------------------
// rom1p1r_128x64_arb
//
// Arbiter and sequencer that shares one 128x64 single-port synchronous ROM
// macro between two requesters: port 0 (fetch side) and port 1 (data side).
// Each port hands over a word address on a valid/ready handshake. The block
// issues at most one ROM read per cycle and captures the returned word into a
// per-port hold register. The word stays there until that port's consumer
// accepts it.
//
// Each port runs a three-state sequence:
//   IDLE -> WAIT   read issued this cycle, ROM data arrives next cycle
//   WAIT -> HOLD   word captured, response presented to the consumer
//   HOLD -> IDLE   consumer popped the word and no new read was granted
//   HOLD -> WAIT   consumer popped the word and a new read was granted
//                  in the same cycle (pop-and-reissue)
//
// Parameters
//   RR          1: round-robin between contending ports
//               0: fixed priority, port 0 always wins
//
// Ports
//   clk         single clock for this block and the ROM macro
//   reset_n     asynchronous active-low reset
//   req0_valid  port 0 read request
//   req0_ready  port 0 request accepted this cycle (combinational)
//   req0_addr   port 0 word address
//   rsp0_valid  port 0 response word valid
//   rsp0_data   port 0 response word
//   rsp0_ready  port 0 consumer accepts the response
//   req1_* / rsp1_*  same as port 0, for port 1
//   rom_ceb     ROM chip enable, active-low (macro CEB)
//   rom_a       ROM word address (macro A)
//   rom_q       ROM read data (macro Q), valid the cycle after CEB=0
// ---------------------------------------------------------------------------
module rom1p1r_128x64_arb #(
   parameter bit RR = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,

   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [6:0]  req0_addr,
   output logic        rsp0_valid,
   output logic [63:0] rsp0_data,
   input  logic        rsp0_ready,

   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [6:0]  req1_addr,
   output logic        rsp1_valid,
   output logic [63:0] rsp1_data,
   input  logic        rsp1_ready,

   output logic        rom_ceb,
   output logic [6:0]  rom_a,
   input  logic [63:0] rom_q
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } port_state_e;

   // Per-port sequencing state and hold registers.
   port_state_e state0_q, state0_d;
   port_state_e state1_q, state1_d;
   logic [63:0] hold0_q, hold0_d;
   logic [63:0] hold1_q, hold1_d;

   // Port that won the most recent issue: 0 or 1. Reset to 1 so that the
   // first contention after reset goes to port 0.
   logic        last_grant_q, last_grant_d;
   // Port whose read is in flight in the ROM; steers the captured rom_q.
   logic        issue_port_q, issue_port_d;

   logic        eligible0, eligible1;
   logic        want0, want1;
   logic        pick1;
   logic        grant0, grant1;
   logic        issue;

   // Next state of one port's sequence, given whether it was granted a new
   // read and whether its consumer is popping the held word this cycle.
   function automatic port_state_e next_state(
      input port_state_e cur,
      input logic        grant,
      input logic        pop
   );
      port_state_e nxt;
      nxt = cur;
      unique case (cur)
         ST_IDLE: nxt = grant ? ST_WAIT : ST_IDLE;
         ST_WAIT: nxt = ST_HOLD;
         ST_HOLD: begin
            if (pop) nxt = grant ? ST_WAIT : ST_IDLE;
            else     nxt = ST_HOLD;
         end
         default: nxt = ST_IDLE;
      endcase
      return nxt;
   endfunction

   // ------------------------------------------------------------------------
   // Arbitration and issue
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned in this block gets a value on every path
      // (defaults first), so no latch is inferred.
      eligible0 = 1'b0;
      eligible1 = 1'b0;
      want0     = 1'b0;
      want1     = 1'b0;
      pick1     = 1'b0;
      grant0    = 1'b0;
      grant1    = 1'b0;

      // A port may take a new request when nothing is outstanding, or when
      // its held word is being popped in this very cycle.
      eligible0 = (state0_q == ST_IDLE) | ((state0_q == ST_HOLD) & rsp0_ready);
      eligible1 = (state1_q == ST_IDLE) | ((state1_q == ST_HOLD) & rsp1_ready);

      want0 = req0_valid & eligible0;
      want1 = req1_valid & eligible1;

      // Contention winner: round-robin hands it to the port that did not win
      // last; fixed priority always favours port 0.
      pick1 = RR ? ~last_grant_q : 1'b0;

      // reset_n is folded in so that no request is accepted and the ROM is
      // never enabled while reset is held, even though the arbiter inputs
      // are combinational from the request ports.
      grant0 = want0 & (~want1 | ~pick1) & reset_n;
      grant1 = want1 & (~want0 |  pick1) & reset_n;
   end

   assign issue      = grant0 | grant1;
   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign rom_ceb    = ~issue;
   assign rom_a      = grant1 ? req1_addr : req0_addr;

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state0_d     = next_state(state0_q, grant0, rsp0_ready);
      state1_d     = next_state(state1_q, grant1, rsp1_ready);

      last_grant_d = issue ? grant1 : last_grant_q;
      issue_port_d = issue ? grant1 : issue_port_q;

      // The hold register only changes when the ROM word for that port
      // arrives. On pop-and-reissue the old word is left in place until the
      // new one is captured a cycle later.
      hold0_d = hold0_q;
      hold1_d = hold1_q;
      if ((state0_q == ST_WAIT) && (issue_port_q == 1'b0)) hold0_d = rom_q;
      if ((state1_q == ST_WAIT) && (issue_port_q == 1'b1)) hold1_d = rom_q;
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   // Asynchronous reset drops any in-flight read and any held response at
   // once; the response data registers are cleared along with the state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state0_q     <= ST_IDLE;
         state1_q     <= ST_IDLE;
         hold0_q      <= '0;
         hold1_q      <= '0;
         last_grant_q <= 1'b1;
         issue_port_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values of its inputs, independent of statement order.
         state0_q     <= state0_d;
         state1_q     <= state1_d;
         hold0_q      <= hold0_d;
         hold1_q      <= hold1_d;
         last_grant_q <= last_grant_d;
         issue_port_q <= issue_port_d;
      end
   end

   // Responses come straight from registers; rom_q never reaches an output
   // except through a hold register.
   assign rsp0_valid = (state0_q == ST_HOLD);
   assign rsp1_valid = (state1_q == ST_HOLD);
   assign rsp0_data  = hold0_q;
   assign rsp1_data  = hold1_q;

endmodule

// File: tb/tb_rom1p1r_128x64_arb.sv
// ---------------------------------------------------------------------------
// tb_rom1p1r_128x64_arb
//
// Self-checking bench. Two instances share all request/response inputs:
// u_rr (round-robin) and u_fp (fixed priority). Each instance drives its own
// behavioural ROM, word[i] = 64'hF000_0000_0000_0000 | i.
//
// A transaction-level reference model tracks, per instance and per port,
// whether a read is outstanding, the cycle it was issued and its address.
// A response is visible from two cycles after issue until popped. Every
// cycle the model's expected ready/ceb/address/response values are compared
// against both instances. Directed phases add hand-derived expectations.
// ---------------------------------------------------------------------------
module tb_rom1p1r_128x64_arb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;
   logic       req0_valid, req1_valid;
   logic [6:0] req0_addr, req1_addr;
   logic       rsp0_ready, rsp1_ready;

   logic [1:0]  rdy0, rdy1, vld0, vld1, ceb;
   logic [6:0]  a_o [2];
   logic [63:0] d0 [2];
   logic [63:0] d1 [2];
   logic [63:0] rq [2];

   rom1p1r_128x64_arb #(.RR(1'b1)) u_rr (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_ready(rdy0[0]), .req0_addr(req0_addr),
      .rsp0_valid(vld0[0]), .rsp0_data(d0[0]), .rsp0_ready(rsp0_ready),
      .req1_valid(req1_valid), .req1_ready(rdy1[0]), .req1_addr(req1_addr),
      .rsp1_valid(vld1[0]), .rsp1_data(d1[0]), .rsp1_ready(rsp1_ready),
      .rom_ceb(ceb[0]), .rom_a(a_o[0]), .rom_q(rq[0])
   );

   rom1p1r_128x64_arb #(.RR(1'b0)) u_fp (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_ready(rdy0[1]), .req0_addr(req0_addr),
      .rsp0_valid(vld0[1]), .rsp0_data(d0[1]), .rsp0_ready(rsp0_ready),
      .req1_valid(req1_valid), .req1_ready(rdy1[1]), .req1_addr(req1_addr),
      .rsp1_valid(vld1[1]), .rsp1_data(d1[1]), .rsp1_ready(rsp1_ready),
      .rom_ceb(ceb[1]), .rom_a(a_o[1]), .rom_q(rq[1])
   );

   function automatic logic [63:0] word(input logic [6:0] a);
      return 64'hF000_0000_0000_0000 | {57'd0, a};
   endfunction

   // Behavioural ROM macros: sample CEB/A on the edge, Q valid afterwards.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++)
         if (!ceb[k]) rq[k] <= word(a_o[k]);
   end

   int n_cmp = 0;
   int n_bad = 0;
   string nm [2] = '{"rr", "fp"};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model state: [instance][port]
   // ------------------------------------------------------------------------
   bit         m_busy  [2][2];
   int         m_issue [2][2];
   logic [6:0] m_addr  [2][2];
   bit         m_last  [2];
   int         cyc = 0;

   // One clock cycle: drive inputs after the falling edge, compare outputs
   // of both instances against the model, then advance the model.
   task automatic cycle(input bit rst,
                        input bit v0, input logic [6:0] a0, input bit r0,
                        input bit v1, input logic [6:0] a1, input bit r1);
      bit         v [2];
      bit         r [2];
      logic [6:0] a [2];
      @(negedge clk);
      reset_n    = rst;
      req0_valid = v0; req0_addr = a0; rsp0_ready = r0;
      req1_valid = v1; req1_addr = a1; rsp1_ready = r1;
      v[0] = v0; v[1] = v1; r[0] = r0; r[1] = r1; a[0] = a0; a[1] = a1;
      #1;
      for (int k = 0; k < 2; k++) begin
         bit vis [2];
         bit elig [2];
         bit want [2];
         bit g [2];
         bit win;
         if (!rst) begin
            m_busy[k][0] = 1'b0;
            m_busy[k][1] = 1'b0;
            m_last[k]    = 1'b1;
         end
         for (int p = 0; p < 2; p++) begin
            vis[p]  = m_busy[k][p] && (cyc >= m_issue[k][p] + 2);
            elig[p] = !m_busy[k][p] || (vis[p] && r[p]);
            want[p] = v[p] && elig[p] && rst;
         end
         // win=1 means port 1 takes a contended cycle
         win  = (k == 0) ? !m_last[k] : 1'b0;
         g[0] = want[0] && (!want[1] || !win);
         g[1] = want[1] && (!want[0] ||  win);

         check($sformatf("%s req0_ready c%0d", nm[k], cyc), 64'(rdy0[k]), 64'(g[0]));
         check($sformatf("%s req1_ready c%0d", nm[k], cyc), 64'(rdy1[k]), 64'(g[1]));
         check($sformatf("%s rom_ceb c%0d", nm[k], cyc), 64'(ceb[k]), 64'(!(g[0] || g[1])));
         check($sformatf("%s rom_a c%0d", nm[k], cyc), 64'(a_o[k]), 64'(g[1] ? a1 : a0));
         check($sformatf("%s rsp0_valid c%0d", nm[k], cyc), 64'(vld0[k]), 64'(vis[0]));
         check($sformatf("%s rsp1_valid c%0d", nm[k], cyc), 64'(vld1[k]), 64'(vis[1]));
         if (vis[0]) check($sformatf("%s rsp0_data c%0d", nm[k], cyc), d0[k], word(m_addr[k][0]));
         if (vis[1]) check($sformatf("%s rsp1_data c%0d", nm[k], cyc), d1[k], word(m_addr[k][1]));

         for (int p = 0; p < 2; p++) begin
            if (g[p]) begin
               m_busy[k][p]  = 1'b1;
               m_issue[k][p] = cyc;
               m_addr[k][p]  = a[p];
            end else if (vis[p] && r[p]) begin
               m_busy[k][p] = 1'b0;
            end
         end
         if (g[0] || g[1]) m_last[k] = g[1];
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 7'h00, 1'b1, 1'b0, 7'h00, 1'b1);
   endtask

   // ------------------------------------------------------------------------
   // Directed vectors: single read on port 0, then backpressure and
   // pop-and-reissue on port 1. Expected values apply to both instances.
   // ------------------------------------------------------------------------
   typedef struct {
      bit         v0; logic [6:0] a0; bit r0;
      bit         v1; logic [6:0] a1; bit r1;
      bit         e_ceb;
      logic [6:0] e_a;
      bit         e_rdy0, e_rdy1, e_vld0, e_vld1;
      logic [63:0] e_data;
   } vec_t;

   function automatic vec_t mk(input bit v0, input logic [6:0] a0, input bit r0,
                               input bit v1, input logic [6:0] a1, input bit r1,
                               input bit e_ceb, input logic [6:0] e_a,
                               input bit e_rdy0, input bit e_rdy1,
                               input bit e_vld0, input bit e_vld1,
                               input logic [63:0] e_data);
      vec_t t;
      t.v0 = v0; t.a0 = a0; t.r0 = r0; t.v1 = v1; t.a1 = a1; t.r1 = r1;
      t.e_ceb = e_ceb; t.e_a = e_a; t.e_rdy0 = e_rdy0; t.e_rdy1 = e_rdy1;
      t.e_vld0 = e_vld0; t.e_vld1 = e_vld1; t.e_data = e_data;
      return t;
   endfunction

   vec_t vecs [$];

   initial begin
      reset_n = 1'b0;
      req0_valid = 1'b0; req0_addr = '0; rsp0_ready = 1'b0;
      req1_valid = 1'b0; req1_addr = '0; rsp1_ready = 1'b0;

      // ---- reset: requests ignored, ROM disabled, responses cleared ----
      cycle(1'b0, 1'b1, 7'h01, 1'b0, 1'b1, 7'h02, 1'b0);
      cycle(1'b0, 1'b1, 7'h01, 1'b0, 1'b1, 7'h02, 1'b0);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("%s reset rsp0_data", nm[k]), d0[k], 64'd0);
         check($sformatf("%s reset rsp1_data", nm[k]), d1[k], 64'd0);
         check($sformatf("%s reset rom_ceb", nm[k]), 64'(ceb[k]), 64'd1);
      end
      idle(2);

      // ---- table-driven directed sequence ----
      //            v0 a0    r0 v1 a1    r1  ceb a     rdy0 rdy1 vld0 vld1 data
      vecs.push_back(mk(1, 7'h05, 1, 0, 7'h00, 0, 0, 7'h05, 1, 0, 0, 0, 64'd0));
      vecs.push_back(mk(0, 7'h05, 1, 0, 7'h00, 0, 1, 7'h05, 0, 0, 0, 0, 64'd0));
      vecs.push_back(mk(0, 7'h05, 1, 0, 7'h00, 0, 1, 7'h05, 0, 0, 1, 0, 64'hF000_0000_0000_0005));
      vecs.push_back(mk(0, 7'h00, 1, 0, 7'h00, 0, 1, 7'h00, 0, 0, 0, 0, 64'd0));
      vecs.push_back(mk(0, 7'h00, 1, 1, 7'h7F, 0, 0, 7'h7F, 0, 1, 0, 0, 64'd0));
      vecs.push_back(mk(0, 7'h00, 1, 1, 7'h7F, 0, 1, 7'h00, 0, 0, 0, 0, 64'd0));
      for (int i = 0; i < 10; i++)
         vecs.push_back(mk(0, 7'h00, 1, 1, 7'h7F, 0, 1, 7'h00, 0, 0, 0, 1, 64'hF000_0000_0000_007F));
      vecs.push_back(mk(0, 7'h00, 1, 1, 7'h00, 1, 0, 7'h00, 0, 1, 0, 1, 64'hF000_0000_0000_007F));
      vecs.push_back(mk(0, 7'h00, 1, 0, 7'h00, 1, 1, 7'h00, 0, 0, 0, 0, 64'd0));
      vecs.push_back(mk(0, 7'h00, 1, 0, 7'h00, 1, 1, 7'h00, 0, 0, 0, 1, 64'hF000_0000_0000_0000));
      vecs.push_back(mk(0, 7'h00, 1, 0, 7'h00, 1, 1, 7'h00, 0, 0, 0, 0, 64'd0));

      for (int i = 0; i < vecs.size(); i++) begin
         cycle(1'b1, vecs[i].v0, vecs[i].a0, vecs[i].r0, vecs[i].v1, vecs[i].a1, vecs[i].r1);
         for (int k = 0; k < 2; k++) begin
            check($sformatf("%s vec%0d ceb", nm[k], i), 64'(ceb[k]), 64'(vecs[i].e_ceb));
            check($sformatf("%s vec%0d a", nm[k], i), 64'(a_o[k]), 64'(vecs[i].e_a));
            check($sformatf("%s vec%0d rdy0", nm[k], i), 64'(rdy0[k]), 64'(vecs[i].e_rdy0));
            check($sformatf("%s vec%0d rdy1", nm[k], i), 64'(rdy1[k]), 64'(vecs[i].e_rdy1));
            check($sformatf("%s vec%0d vld0", nm[k], i), 64'(vld0[k]), 64'(vecs[i].e_vld0));
            check($sformatf("%s vec%0d vld1", nm[k], i), 64'(vld1[k]), 64'(vecs[i].e_vld1));
            if (vecs[i].e_vld0) check($sformatf("%s vec%0d data0", nm[k], i), d0[k], vecs[i].e_data);
            if (vecs[i].e_vld1) check($sformatf("%s vec%0d data1", nm[k], i), d1[k], vecs[i].e_data);
         end
      end

      // ---- contention: both ports streaming, grants alternate from port 0 ----
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 1'b1, 7'h10, 1'b1, 1'b1, 7'h20, 1'b1);
         for (int k = 0; k < 2; k++) begin
            check($sformatf("%s contend%0d rdy0", nm[k], i), 64'(rdy0[k]), 64'(i % 2 == 0));
            check($sformatf("%s contend%0d rdy1", nm[k], i), 64'(rdy1[k]), 64'(i % 2 == 1));
            check($sformatf("%s contend%0d ceb", nm[k], i), 64'(ceb[k]), 64'd0);
         end
      end
      idle(3);

      // ---- policy difference: port 0 won last, then both ask at once ----
      cycle(1'b1, 1'b1, 7'h11, 1'b1, 1'b0, 7'h00, 1'b1);
      idle(3);
      cycle(1'b1, 1'b1, 7'h12, 1'b1, 1'b1, 7'h22, 1'b1);
      check("rr after p0 grants p1", 64'(rdy1[0]), 64'd1);
      check("rr after p0 holds p0", 64'(rdy0[0]), 64'd0);
      check("fp after p0 grants p0", 64'(rdy0[1]), 64'd1);
      check("fp after p0 holds p1", 64'(rdy1[1]), 64'd0);
      idle(4);

      // ---- reset mid-flight: port 1 holding, port 0 in WAIT ----
      cycle(1'b1, 1'b0, 7'h00, 1'b1, 1'b1, 7'h44, 1'b0);
      cycle(1'b1, 1'b0, 7'h00, 1'b1, 1'b0, 7'h00, 1'b0);
      cycle(1'b1, 1'b0, 7'h00, 1'b1, 1'b0, 7'h00, 1'b0);
      cycle(1'b1, 1'b1, 7'h33, 1'b1, 1'b0, 7'h00, 1'b0);
      for (int j = 0; j < 2; j++) begin
         cycle(1'b0, 1'b1, 7'h33, 1'b1, 1'b1, 7'h44, 1'b1);
         for (int k = 0; k < 2; k++) begin
            check($sformatf("%s midrst%0d vld0", nm[k], j), 64'(vld0[k]), 64'd0);
            check($sformatf("%s midrst%0d vld1", nm[k], j), 64'(vld1[k]), 64'd0);
            check($sformatf("%s midrst%0d ceb", nm[k], j), 64'(ceb[k]), 64'd1);
            check($sformatf("%s midrst%0d rdy0", nm[k], j), 64'(rdy0[k]), 64'd0);
            check($sformatf("%s midrst%0d rdy1", nm[k], j), 64'(rdy1[k]), 64'd0);
         end
      end
      for (int j = 0; j < 4; j++) begin
         cycle(1'b1, 1'b0, 7'h00, 1'b1, 1'b0, 7'h00, 1'b1);
         for (int k = 0; k < 2; k++) begin
            check($sformatf("%s stale%0d vld0", nm[k], j), 64'(vld0[k]), 64'd0);
            check($sformatf("%s stale%0d vld1", nm[k], j), 64'(vld1[k]), 64'd0);
         end
      end
      cycle(1'b1, 1'b1, 7'h50, 1'b1, 1'b1, 7'h60, 1'b1);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("%s post-reset first contend rdy0", nm[k]), 64'(rdy0[k]), 64'd1);
         check($sformatf("%s post-reset first contend rdy1", nm[k]), 64'(rdy1[k]), 64'd0);
      end
      idle(3);

      // ---- randomized traffic against the model ----
      for (int i = 0; i < 3000; i++) begin
         bit rst;
         rst = ($urandom_range(0, 299) != 0);
         cycle(rst,
               1'($urandom_range(0, 3) != 0), 7'($urandom), 1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 3) != 0), 7'($urandom), 1'($urandom_range(0, 2) != 0));
      end
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
